instr_encoder_loader: RTL



---
 rtl/mips_isa_pkg.sv | 78 +++++++
 rtl/instr_word_encoder.sv | 43 ++++
 rtl/instr_encoder_loader.sv | 101 ++++++++++
 3 files changed

// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the control decoder and the instruction encoder:
// mnemonic codes, opcodes, funct codes, field widths and format builders.
package mips_isa_pkg;

   localparam int OP_W    = 6;
   localparam int REG_W   = 5;
   localparam int SHAMT_W = 5;
   localparam int FUNCT_W = 6;
   localparam int IMM_W   = 16;
   localparam int TGT_W   = 26;

   typedef enum logic [4:0] {
      MN_ADD   = 5'd0,
      MN_SUB   = 5'd1,
      MN_AND   = 5'd2,
      MN_OR    = 5'd3,
      MN_SLT   = 5'd4,
      MN_J     = 5'd5,
      MN_JAL   = 5'd6,
      MN_BEQ   = 5'd7,
      MN_BNE   = 5'd8,
      MN_ADDI  = 5'd9,
      MN_ADDIU = 5'd10,
      MN_SLTI  = 5'd11,
      MN_ANDI  = 5'd12,
      MN_ORI   = 5'd13,
      MN_LUI   = 5'd14,
      MN_LW    = 5'd15,
      MN_SW    = 5'd16
   } mnem_e;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
   localparam logic [OP_W-1:0] OP_J     = 6'd2;
   localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
   localparam logic [OP_W-1:0] OP_BNE   = 6'd5;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'd8;
   localparam logic [OP_W-1:0] OP_ADDIU = 6'd9;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'd10;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'd12;
   localparam logic [OP_W-1:0] OP_ORI   = 6'd13;
   localparam logic [OP_W-1:0] OP_LUI   = 6'd15;
   localparam logic [OP_W-1:0] OP_LW    = 6'd35;
   localparam logic [OP_W-1:0] OP_SW    = 6'd43;

   localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
   localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
   localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
   localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
   localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   function automatic logic [31:0] r_format(input logic [FUNCT_W-1:0] funct,
                                            input logic [REG_W-1:0] rs,
                                            input logic [REG_W-1:0] rt,
                                            input logic [REG_W-1:0] rd,
                                            input logic [SHAMT_W-1:0] shamt);
      return {OP_RTYPE, rs, rt, rd, shamt, funct};
   endfunction

   function automatic logic [31:0] i_format(input logic [OP_W-1:0] op,
                                            input logic [REG_W-1:0] rs,
                                            input logic [REG_W-1:0] rt,
                                            input logic [IMM_W-1:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] j_format(input logic [OP_W-1:0] op,
                                            input logic [TGT_W-1:0] target);
      return {op, target};
   endfunction

endpackage

// File: rtl/instr_word_encoder.sv
// Combinational assembler: mnemonic plus operand fields to a 32-bit MIPS word.
// Codes outside the mnemonic table raise illegal and produce a zero word.
module instr_word_encoder
   import mips_isa_pkg::*;
(
   input  logic [4:0]       mnem,
   input  logic [REG_W-1:0] rs,
   input  logic [REG_W-1:0] rt,
   input  logic [REG_W-1:0] rd,
   input  logic [4:0]       shamt,
   input  logic [15:0]      imm16,
   input  logic [25:0]      target26,
   output logic [31:0]      word,
   output logic             illegal
);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (mnem)
         MN_ADD:   word = r_format(FN_ADD, rs, rt, rd, shamt);
         MN_SUB:   word = r_format(FN_SUB, rs, rt, rd, shamt);
         MN_AND:   word = r_format(FN_AND, rs, rt, rd, shamt);
         MN_OR:    word = r_format(FN_OR,  rs, rt, rd, shamt);
         MN_SLT:   word = r_format(FN_SLT, rs, rt, rd, shamt);
         MN_J:     word = j_format(OP_J,   target26);
         MN_JAL:   word = j_format(OP_JAL, target26);
         MN_BEQ:   word = i_format(OP_BEQ,   rs, rt, imm16);
         MN_BNE:   word = i_format(OP_BNE,   rs, rt, imm16);
         MN_ADDI:  word = i_format(OP_ADDI,  rs, rt, imm16);
         MN_ADDIU: word = i_format(OP_ADDIU, rs, rt, imm16);
         MN_SLTI:  word = i_format(OP_SLTI,  rs, rt, imm16);
         MN_ANDI:  word = i_format(OP_ANDI,  rs, rt, imm16);
         MN_ORI:   word = i_format(OP_ORI,   rs, rt, imm16);
         // LUI has no source register, so the rs slot is always zero
         MN_LUI:   word = i_format(OP_LUI, '0, rt, imm16);
         MN_LW:    word = i_format(OP_LW,    rs, rt, imm16);
         MN_SW:    word = i_format(OP_SW,    rs, rt, imm16);
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts encoded-instruction requests over valid/ready and
// writes each word to instruction memory at sequential word addresses.
module instr_encoder_loader
   import mips_isa_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 256,
   parameter int          CNT_W     = 9
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       mnem,
   input  logic [4:0]       rs,
   input  logic [4:0]       rt,
   input  logic [4:0]       rd,
   input  logic [4:0]       shamt,
   input  logic [15:0]      imm16,
   input  logic [25:0]      target26,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [CNT_W-1:0] word_count,
   output logic             full,
   output logic             err,
   output logic [7:0]       err_count
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

   state_e      state;
   state_e      state_next;
   logic [31:0] enc_word;
   logic        enc_illegal;
   logic        take;

   instr_word_encoder u_encoder (
      .mnem     (mnem),
      .rs       (rs),
      .rt       (rt),
      .rd       (rd),
      .shamt    (shamt),
      .imm16    (imm16),
      .target26 (target26),
      .word     (enc_word),
      .illegal  (enc_illegal)
   );

   // clear drops any handshake offered in the same cycle
   assign take = in_valid && in_ready && !clear;

   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (take && !enc_illegal) state_next = ST_WRITE;
            ST_WRITE: state_next = (word_count == LAST) ? ST_FULL : ST_IDLE;
            ST_FULL:  state_next = ST_FULL;
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready = (state == ST_IDLE) && !reset;
      mem_we   = (state == ST_WRITE) && !clear && !reset;
      full     = (state == ST_FULL);
   end

   // The address only advances on a completed write, so FULL parks it one past the last word
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_addr   <= BASE_ADDR;
         mem_wdata  <= '0;
         word_count <= '0;
         err        <= 1'b0;
         err_count  <= '0;
      end else begin
         err <= take && enc_illegal;
         if (take && enc_illegal && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
         if (take && !enc_illegal) mem_wdata <= enc_word;
         if (clear) begin
            mem_addr   <= BASE_ADDR;
            word_count <= '0;
         end else if (state == ST_WRITE) begin
            mem_addr   <= mem_addr + 32'd4;
            word_count <= word_count + CNT_W'(1);
         end
      end
   end

endmodule
